// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR tap sequencer:
// sequencer states, default widths and the accumulator width helper.
package fir_pkg;

  // Default geometry of the filter
  localparam int FIR_N_TAPS = 4;
  localparam int FIR_BW_IN  = 6;
  localparam int FIR_BW_OUT = 8;

  // Sequencer states: coefficient load, wait for sample, MAC sweep, publish
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fir_state_e;

  // Accumulator width that holds the sum of n_taps full-width products
  // without overflow: one product is 2*bw_in bits, plus clog2(n_taps)
  // guard bits for the additions.
  function automatic int fir_acc_width(input int bw_in, input int n_taps);
    return 2 * bw_in + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate unit. One product per enabled cycle is
// sign-extended and added to the accumulator; clr zeroes it for a new sample.
// acc_sum exposes acc + product so the caller can capture the final result
// on the same edge that performs the last accumulation.
module fir_mac
  import fir_pkg::*;
#(
  parameter int BW_in      = FIR_BW_IN,
  parameter int BW_product = 2 * BW_in,
  parameter int BW_acc     = fir_acc_width(BW_in, FIR_N_TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [BW_in-1:0]  coef,
  input  logic signed [BW_in-1:0]  sample,
  output logic signed [BW_acc-1:0] acc_sum
);

  logic signed [BW_product-1:0] prod;
  logic signed [BW_acc-1:0]     prod_ext;
  logic signed [BW_acc-1:0]     acc_d;
  logic signed [BW_acc-1:0]     acc_q;

  // Full-width signed product, sign-extended to the accumulator width
  always_comb begin
    prod     = $signed({{(BW_product-BW_in){coef[BW_in-1]}}, coef}) *
               $signed({{(BW_product-BW_in){sample[BW_in-1]}}, sample});
    prod_ext = {{(BW_acc-BW_product){prod[BW_product-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
  end

  // Next accumulator value: clear has priority over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_sum;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed N-tap FIR controller around one shared multiplier.
// After reset it loads N_TAPS coefficients serially from x_in, then accepts
// one sample at a time, sweeps the taps with one MAC per cycle and publishes
// the low BW_out bits of the sum with a one-cycle y_valid pulse.
// coef[0] multiplies the newest sample (x_hist[0]).
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS     = FIR_N_TAPS,
  parameter int BW_in      = FIR_BW_IN,
  parameter int BW_product = 2 * BW_in,
  parameter int BW_acc     = fir_acc_width(BW_in, N_TAPS),
  parameter int BW_out     = FIR_BW_OUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [BW_in-1:0] x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic                    coef_done,
  output logic                    busy,
  output logic [BW_out-1:0]       y_out,
  output logic                    y_valid
);

  localparam int            KW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

  // Output is the low bits of the accumulator: wrap, no rounding/saturation
  function automatic logic [BW_out-1:0] trunc_out(input logic signed [BW_acc-1:0] v);
    return BW_out'(v);
  endfunction

  fir_state_e state_d, state_q;

  logic [KW-1:0] idx_d, idx_q;   // coefficient write index (LOAD)
  logic [KW-1:0] k_d, k_q;       // tap index (RUN)

  logic signed [BW_in-1:0] coef_d   [N_TAPS];
  logic signed [BW_in-1:0] coef_q   [N_TAPS];
  logic signed [BW_in-1:0] x_hist_d [N_TAPS];
  logic signed [BW_in-1:0] x_hist_q [N_TAPS];

  logic              coef_done_d, coef_done_q;
  logic [BW_out-1:0] y_out_d, y_out_q;
  logic              y_valid_d, y_valid_q;

  logic                    xfer;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [BW_in-1:0] tap_coef;
  logic signed [BW_in-1:0] tap_x;
  logic signed [BW_acc-1:0] mac_sum;

  // Handshake and status decoded straight from the state register
  assign x_ready   = (state_q == ST_LOAD) || (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign coef_done = coef_done_q;
  assign y_out     = y_out_q;
  assign y_valid   = y_valid_q;
  assign xfer      = x_valid && x_ready;

  // Tap mux: select the coefficient/sample pair for the current tap
  always_comb begin
    tap_coef = coef_q[k_q];
    tap_x    = x_hist_q[k_q];
  end

  fir_mac #(
    .BW_in      (BW_in),
    .BW_product (BW_product),
    .BW_acc     (BW_acc)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .coef    (tap_coef),
    .sample  (tap_x),
    .acc_sum (mac_sum)
  );

  // Sequencer next-state, register-file updates and result capture
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    coef_d      = coef_q;
    x_hist_d    = x_hist_q;
    coef_done_d = coef_done_q;
    y_out_d     = y_out_q;
    y_valid_d   = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          coef_d[idx_q] = x_in;
          idx_d         = idx_q + KW'(1);
          if (idx_q == K_LAST) begin
            idx_d       = '0;
            coef_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (xfer) begin
          x_hist_d[0] = x_in;
          for (int i = 1; i < N_TAPS; i++) begin
            x_hist_d[i] = x_hist_q[i-1];
          end
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        mac_en = 1'b1;
        k_d    = k_q + KW'(1);
        if (k_q == K_LAST) begin
          // Capture the sum including the last product so y_out is already
          // valid during the DONE cycle that carries the pulse.
          k_d       = '0;
          y_out_d   = trunc_out(mac_sum);
          y_valid_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, regfile, delay line and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      k_q         <= '0;
      coef_done_q <= 1'b0;
      y_out_q     <= '0;
      y_valid_q   <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i]   <= '0;
        x_hist_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      coef_done_q <= coef_done_d;
      y_out_q     <= y_out_d;
      y_valid_q   <= y_valid_d;
      coef_q      <= coef_d;
      x_hist_q    <= x_hist_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed vectors with literal expectations
// plus a cycle-level reference model compared on every clock.
module tb_fir_tap_sequencer;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [5:0] x_in;
  logic              x_valid;
  logic              x_ready;
  logic              coef_done;
  logic              busy;
  logic [7:0]        y_out;
  logic              y_valid;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .coef_done (coef_done),
    .busy      (busy),
    .y_out     (y_out),
    .y_valid   (y_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: coefficients, sample history and scheduled results
  typedef struct {
    int due;
    int val;
  } pend_t;

  pend_t pend[$];
  int    m_coef[N];
  int    m_hist[N];
  int    m_ncoef    = 0;
  int    m_free_at  = 0;
  int    m_last_t   = -1000;
  int    m_yout     = 0;
  int    m_last_vld = -1;
  int    m_last_sum = 0;
  bit    m_init     = 1'b0;
  bit    m_accepted = 1'b0;
  int    cyc        = 0;
  int    nout       = 0;

  // DUT outputs as seen at the last compare point
  bit s_vld;
  int s_y, s_done, s_rdy, s_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against the model for the current cycle
  task automatic compare();
    bit er, eb, ev;
    s_vld  = (y_valid === 1'b1);
    s_y    = int'(y_out);
    s_done = int'(coef_done);
    s_rdy  = int'(x_ready);
    s_busy = int'(busy);
    if (!m_init) return;
    er = (m_ncoef < N) || (cyc >= m_free_at);
    eb = (m_ncoef == N) && (cyc > m_last_t) && (cyc <= m_last_t + N);
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (ev) begin
      m_yout = pend[0].val;
      void'(pend.pop_front());
      if (m_last_vld >= 0) chk("y_valid_spacing", (cyc - m_last_vld >= N + 2) ? 1 : 0, 1);
      m_last_vld = cyc;
      nout++;
    end
    chk("x_ready", s_rdy, int'(er));
    chk("busy", s_busy, int'(eb));
    chk("coef_done", s_done, (m_ncoef == N) ? 1 : 0);
    chk("y_valid", int'(s_vld), int'(ev));
    chk("y_out", s_y, m_yout);
  endtask

  // Advance the model by the transfer sampled at this rising edge
  task automatic model_update();
    int sum;
    m_accepted = 1'b0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_coef[i] = 0;
        m_hist[i] = 0;
      end
      m_ncoef    = 0;
      m_free_at  = 0;
      m_last_t   = -1000;
      m_yout     = 0;
      m_last_vld = -1;
      pend.delete();
      m_init     = 1'b1;
    end else if (m_init && x_valid && ((m_ncoef < N) || (cyc >= m_free_at))) begin
      m_accepted = 1'b1;
      if (m_ncoef < N) begin
        m_coef[m_ncoef] = int'(x_in);
        m_ncoef++;
      end else begin
        pend_t p;
        for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(x_in);
        sum = 0;
        for (int i = 0; i < N; i++) sum += m_coef[i] * m_hist[i];
        m_last_sum = sum;
        p.due = cyc + N + 1;
        p.val = sum & 255;
        pend.push_back(p);
        m_last_t  = cyc;
        m_free_at = cyc + N + 2;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    x_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x_in    = 6'(c[i]);
      tick();
    end
    x_valid = 1'b0;
  endtask

  task automatic send(input int x);
    bit ok = 1'b0;
    x_valid = 1'b1;
    x_in    = 6'(x);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_accepted) begin
        ok = 1'b1;
        break;
      end
    end
    x_valid = 1'b0;
    if (!ok) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic send_chk(input string name, input int x, input int exp);
    int lat = 0;
    bit got = 1'b0;
    send(x);
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (s_vld) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk(name, s_y, exp);
      chk({name, "_latency"}, lat, 5);
    end
  endtask

  initial begin
    int vcount;
    int rstart;
    reset   = 1'b1;
    x_valid = 1'b0;
    x_in    = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_x_ready", s_rdy, 1);
    chk("rst_coef_done", s_done, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_y_out", s_y, 0);
    chk("rst_y_valid", int'(s_vld), 0);

    // Coefs 1,2,3,4 then an impulse
    load(1, 2, 3, 4);
    tick();
    chk("coef_done_after_load", s_done, 1);
    send_chk("imp0", 1, 1);
    send_chk("imp1", 0, 2);
    send_chk("imp2", 0, 3);
    send_chk("imp3", 0, 4);
    send_chk("imp4", 0, 0);

    // Negative sample, wrapped to 8 bits
    do_reset();
    load(1, 0, 0, 0);
    send_chk("neg5", -5, 'hFB);

    // Most negative squared: 1024 truncates to zero
    do_reset();
    load(-32, 0, 0, 0);
    send_chk("neg32sq", -32, 'h00);
    chk("model_sum_neg32sq", m_last_sum, 1024);

    // Largest positive accumulation
    do_reset();
    load(31, 31, 31, 31);
    send_chk("max1", 31, 'hC1);
    send_chk("max2", 31, 'h82);
    send_chk("max3", 31, 'h43);
    send_chk("max4", 31, 'h04);
    chk("model_sum_max4", m_last_sum, 3844);

    // x_valid held high through RUN/DONE with alternating values
    do_reset();
    load(3, -2, 5, -7);
    x_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      x_in = (i % 2 == 1) ? 6'(7) : 6'(-9);
      tick();
    end
    x_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    send_chk("post_alt", 1, ((3 * 1 + (-2) * m_hist[1] + 5 * m_hist[2] + (-7) * m_hist[3]) & 255));

    // Reset during RUN cycle 2 aborts the sweep and clears coefficients
    send(5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_coef_done", s_done, 0);
    chk("abort_y_out", s_y, 0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_vld) vcount++;
    end
    chk("abort_no_y_valid", vcount, 0);
    load(2, 0, 0, 0);
    send_chk("reload", 3, 6);

    // Random coefficients and samples, two batches
    rstart = nout;
    for (int b = 0; b < 2; b++) begin
      int target;
      do_reset();
      load($urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32,
           $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32);
      target = nout + 260;
      for (int i = 0; i < 4000 && nout < target; i++) begin
        x_valid = ($urandom_range(0, 3) != 0);
        x_in    = 6'($urandom);
        tick();
      end
    end
    x_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("no_pending_results", pend.size(), 0);
    chk("random_outputs_ge_500", (nout - rstart >= 500) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end

endmodule
